lz_hash_feeder: RTL and testbench
=================================

# lz_hash_feeder

Front-end of the Zstd LZ match-finder; sits directly upstream of the Level-0 CAM hash cache. It accepts the raw input byte stream and maintains a 4-byte sliding window. Each cycle it hashes the window and drives it to the cache as a search key. It then captures the cache hit/pointer result, inserts the current position into the cache, and hands a per-position match candidate to the downstream sequence builder.

## Interface
- `HASH_WIDTH`, 32: hash width; must equal the cache's hash width.
- `ADDR_WIDTH`, 32: position/pointer width.
- `MAX_DIST`, 65535: maximum accepted match distance; used only with `LZ_HF_MAX_DIST_EN`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: feeder can accept a byte.
- `in_byte` in 8: stream byte.
- `in_last` in 1: final byte of the stream.
- `search_hash` out HASH_WIDTH: cache search key.
- `hit` in 1: cache hit, combinational from `search_hash`.
- `hit_ptr` in ADDR_WIDTH: cache pointer on hit.
- `update_en` out 1: cache insert strobe.
- `update_hash` out HASH_WIDTH: insert key; always equals `search_hash`.
- `update_ptr` out ADDR_WIDTH: insert position.
- `cand_valid` out 1: candidate valid.
- `cand_ready` in 1: downstream accepts the candidate.
- `cand_pos` out ADDR_WIDTH: position of the candidate's first byte.
- `cand_byte` out 8: literal byte at `cand_pos`.
- `cand_hit` out 1: a match candidate exists.
- `cand_ptr` out ADDR_WIDTH: earlier position with the same hash; 0 when `cand_hit`=0.
- `cand_last` out 1: final candidate of the stream.

## Operation
- **Window:** `win[31:0]` = {b[p+3], b[p+2], b[p+1], b[p]}, where b[p] is the oldest byte and sits in bits [7:0]. Each accepted byte shifts in at bits [31:24].
- **Hash:** `search_hash` = upper HASH_WIDTH bits of (`win` × 32'h9E3779B1) mod 2^32. It is combinational from the S1 register.
- **Pipeline:**
  - S1 holds a window, its `pos` and a `full` flag.
  - S2 is the candidate output register.
  - S1 advances into S2 when S2 is empty or `cand_ready`=1.
  - `in_ready` = S1 empty or S1 advancing, and state is not FLUSH.
- **Cache access:**
  - `update_en`=1 exactly in cycles where S1 advances with `full`=1; `update_ptr`=S1 `pos`.
  - Search and insert share a clock edge, so the lookup sees pre-insert contents. A position never hits itself.
- **Hit qualification:** `cand_hit` = `hit` && (`hit_ptr` < `pos`). A pointer ≥ `pos` comes from a previous stream and is forced to a miss.
- **State machine** (states IDLE, FILL, RUN, FLUSH):
  - IDLE: no bytes buffered. First accepted byte → FILL.
  - FILL: fewer than 4 bytes buffered. The 4th byte loads S1 with `full`=1 → RUN.
  - RUN: each new byte slides the window by one and increments `pos` by 1.
  - `in_last` accepted while in FILL or RUN → FLUSH.
  - FLUSH: the remaining 0-3 buffered bytes are emitted one per advance as literals (`full`=0, `cand_hit`=0, no `update_en`). The final one carries `cand_last`=1, then → IDLE.
- **Short streams:** a stream shorter than 4 bytes emits only literals.
- **Position counter:** `pos` restarts at 0 for each new stream. At the ADDR_WIDTH boundary it wraps modulo 2^ADDR_WIDTH.
- **Candidate count:** every input byte yields exactly one candidate, in order.

## Timing
- **Reset values:** all outputs 0; state IDLE; S1/S2 empty; `in_ready`=1 after reset.
- **Latency:** once the window is full, a byte accepted at edge N produces its candidate at edge N+1, provided S2 is free.
- **Throughput:** 1 byte/cycle sustained under `cand_ready`=1.
- **Output handshake:** S2 contents are held stable while `cand_valid`=1 && `cand_ready`=0. Upstream stalls via `in_ready`=0.
- **Simultaneous events:** `in_last` arriving on the 4th byte goes to FLUSH with S1 full. That window is emitted as a normal hashed candidate, followed by 3 literals.
- **Reset mid-operation:** the pipeline is discarded and `pos` returns to 0. Cache contents are the cache's own responsibility.

## Configuration
- `LZ_HF_MAX_DIST_EN` defined: additionally force `cand_hit`=0 when (`pos` − `hit_ptr`) > MAX_DIST.
- Undefined: no distance limit; the MAX_DIST parameter is unused.

## Structure
- **Package `lz_pkg`:** `HASH_PRIME` constant (32'h9E3779B1), the feeder state enum, and the `MIN_MATCH`=4 constant.
- **Sub-module `lz_hash_mul`:** combinational window-to-hash multiply/shift, reused by later match-finder stages.

## Test plan
- **Basic match:** stream 61 62 63 64 61 62 63 64, last on byte 8. Expect 8 candidates.
  - pos 0-3: miss.
  - pos 4: `cand_hit`=1, `cand_ptr`=0.
  - pos 5-7: literals 62 63 64; pos 7 `cand_last`=1.
  - `update_en` count = 5.
- **Short stream:** 3-byte stream AA BB CC. Expect 3 literals, no `update_en`, `cand_last` on CC.
- **Backpressure:** `cand_ready`=0 for 5 cycles mid-stream. Expect S2 held stable, `in_ready` drops within 1 cycle, no candidate lost or duplicated.
- **Stale pointer:** second stream with the cache preloaded at ptr 100; hit at pos 4. Expect `cand_hit`=0.
- **Distance limit:** with `LZ_HF_MAX_DIST_EN` and MAX_DIST=2, run the basic-match stream. Expect the pos-4 hit suppressed (distance 4).
- **Reset mid-operation:** assert `rst_n` low during RUN. Expect all outputs 0 immediately; the next stream starts at `pos`=0.

Source files
------------

// File: rtl/lz_pkg.sv
// lz_pkg: shared constants and types for the LZ match-finder stages
package lz_pkg;
    localparam logic [31:0] HASH_PRIME = 32'h9E3779B1;
    localparam int MIN_MATCH = 4;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_FILL = 2'd1, ST_RUN = 2'd2, ST_FLUSH = 2'd3;
    typedef enum logic [1:0] {IDLE = ST_IDLE, FILL = ST_FILL, RUN = ST_RUN, FLUSH = ST_FLUSH} hf_state_e;
endpackage

// File: rtl/lz_hash_mul.sv
// lz_hash_mul: multiplicative hash of a 4-byte window (upper HASH_WIDTH bits of win * HASH_PRIME)
module lz_hash_mul
    import lz_pkg::*;
#(
    parameter int HASH_WIDTH = 32
)(
    input  logic [31:0]           win,
    output logic [HASH_WIDTH-1:0] hash
);
    logic [31:0] prod;
    assign prod = win * HASH_PRIME;
    assign hash = prod[31 -: HASH_WIDTH];
endmodule

// File: rtl/lz_hash_feeder.sv
// lz_hash_feeder: byte stream -> 4-byte hashed window -> cache search/insert -> per-position candidate.
// Optional LZ_HF_MAX_DIST_EN rejects hits farther back than MAX_DIST.
module lz_hash_feeder
    import lz_pkg::*;
#(
    parameter int HASH_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_DIST   = 65535
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_byte,
    input  logic                  in_last,
    output logic [HASH_WIDTH-1:0] search_hash,
    input  logic                  hit,
    input  logic [ADDR_WIDTH-1:0] hit_ptr,
    output logic                  update_en,
    output logic [HASH_WIDTH-1:0] update_hash,
    output logic [ADDR_WIDTH-1:0] update_ptr,
    output logic                  cand_valid,
    input  logic                  cand_ready,
    output logic [ADDR_WIDTH-1:0] cand_pos,
    output logic [7:0]            cand_byte,
    output logic                  cand_hit,
    output logic [ADDR_WIDTH-1:0] cand_ptr,
    output logic                  cand_last
);
    hf_state_e             state;
    logic [31:0]           win;
    logic [2:0]            cnt;
    logic [ADDR_WIDTH-1:0] pos;
    logic                  full, s1_vld, adv, acc, dist_ok, hit_q, last_out;
    logic [7:0]            lit;

    lz_hash_mul #(.HASH_WIDTH(HASH_WIDTH)) u_hash (.win(win), .hash(search_hash));

    // cnt = bytes still buffered in win; the oldest of them sits at byte lane 4-cnt
    assign full        = cnt == 3'(MIN_MATCH);
    assign s1_vld      = full || state == FLUSH;
    assign adv         = s1_vld && (!cand_valid || cand_ready);
    assign in_ready    = (!s1_vld || adv) && state != FLUSH;
    assign acc         = in_valid && in_ready;
    assign update_en   = adv && full;
    assign update_hash = search_hash;
    assign update_ptr  = pos;
    assign lit         = cnt == 3'd4 ? win[7:0] : cnt == 3'd3 ? win[15:8] : cnt == 3'd2 ? win[23:16] : win[31:24];
    assign last_out    = state == FLUSH && cnt == 3'd1;
`ifdef LZ_HF_MAX_DIST_EN
    assign dist_ok = (pos - hit_ptr) <= ADDR_WIDTH'(MAX_DIST);
`else
    logic unused_max_dist;
    assign unused_max_dist = ^MAX_DIST;
    assign dist_ok = 1'b1;
`endif
    // pointers at or beyond the current position belong to an earlier stream
    assign hit_q = full && hit && hit_ptr < pos && dist_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            win   <= '0;
            cnt   <= '0;
            pos   <= '0;
        end else begin
            if (acc) win <= {in_byte, win[31:8]};
            case (state)
                IDLE, FILL: if (acc) begin
                    cnt   <= cnt + 3'd1;
                    state <= in_last ? FLUSH : cnt == 3'(MIN_MATCH - 1) ? RUN : FILL;
                end
                RUN: begin
                    cnt <= acc ? 3'(MIN_MATCH) : adv ? 3'(MIN_MATCH - 1) : cnt;
                    pos <= acc ? pos + 1'b1 : pos;
                    if (acc && in_last) state <= FLUSH;
                end
                default: if (adv) begin
                    cnt   <= cnt - 3'd1;
                    pos   <= last_out ? '0 : pos + 1'b1;
                    state <= last_out ? IDLE : FLUSH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_valid <= 1'b0;
            cand_pos   <= '0;
            cand_byte  <= '0;
            cand_hit   <= 1'b0;
            cand_ptr   <= '0;
            cand_last  <= 1'b0;
        end else if (adv) begin
            cand_valid <= 1'b1;
            cand_pos   <= pos;
            cand_byte  <= lit;
            cand_hit   <= hit_q;
            cand_ptr   <= hit_q ? hit_ptr : '0;
            cand_last  <= last_out;
        end else if (cand_ready) begin
            cand_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lz_hash_feeder.sv
// tb_lz_hash_feeder: randomized scoreboard bench for lz_hash_feeder with a behavioural cache stub
module tb_lz_hash_feeder;
    localparam logic [31:0] PRIME = 32'h9E3779B1;
`ifdef LZ_HF_MAX_DIST_EN
    localparam int MD = 2;
    localparam int BASIC_HITS = 0;
`else
    localparam int MD = 65535;
    localparam int BASIC_HITS = 1;
`endif

    logic        clk = 0, rst_n = 1;
    logic        in_valid = 0, in_last = 0, cand_ready = 0;
    logic        in_ready, hit, update_en, cand_valid, cand_hit, cand_last;
    logic [7:0]  in_byte = 0, cand_byte;
    logic [31:0] search_hash, update_hash, hit_ptr, update_ptr, cand_pos, cand_ptr;

    typedef struct { logic [31:0] pos; logic [7:0] b; logic h; logic [31:0] ptr; logic last; } cand_t;
    typedef struct { logic [31:0] hash; logic [31:0] ptr; } upd_t;
    cand_t       exp_c[$];
    upd_t        exp_u[$];
    logic [31:0] stub[logic [31:0]];
    logic [31:0] model[logic [31:0]];
    int          cache_gen = 0;
    int          tests = 0, fails = 0;
    int          n_cand = 0, n_hit = 0, n_upd = 0;
    bit          sb_off = 0, stall = 0, rand_bp = 0, gaps = 0;

    lz_hash_feeder #(.HASH_WIDTH(32), .ADDR_WIDTH(32), .MAX_DIST(MD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .in_last(in_last), .search_hash(search_hash), .hit(hit), .hit_ptr(hit_ptr),
        .update_en(update_en), .update_hash(update_hash), .update_ptr(update_ptr),
        .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_pos(cand_pos), .cand_byte(cand_byte),
        .cand_hit(cand_hit), .cand_ptr(cand_ptr), .cand_last(cand_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog: simulation did not complete");
    end

    // cache stub: combinational lookup, insert lands just after the edge that issued it
    always @(search_hash or cache_gen) begin
        hit = stub.exists(search_hash);
        hit_ptr = hit ? stub[search_hash] : 32'h0;
    end

    initial begin : ins
        logic pend;
        logic [31:0] ph, pp;
        forever begin
            @(negedge clk);
            pend = update_en;
            ph = update_hash;
            pp = update_ptr;
            @(posedge clk);
            #1;
            if (pend) begin
                stub[ph] = pp;
                cache_gen++;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        cand_ready = stall ? 1'b0 : rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: pops the reference queues whenever the DUT presents a candidate or an insert
    initial begin : mon
        cand_t c;
        upd_t u;
        forever begin
            @(negedge clk);
            if (rst_n && !sb_off) begin
                if (cand_valid && cand_ready) begin
                    n_cand++;
                    n_hit += int'(cand_hit);
                    chk("cand_expected", exp_c.size() != 0, 1);
                    if (exp_c.size() != 0) begin
                        c = exp_c.pop_front();
                        chk("cand_pos", cand_pos, c.pos);
                        chk("cand_byte", cand_byte, c.b);
                        chk("cand_hit", cand_hit, c.h);
                        chk("cand_ptr", cand_ptr, c.ptr);
                        chk("cand_last", cand_last, c.last);
                    end
                end
                if (update_en) begin
                    n_upd++;
                    chk("upd_expected", exp_u.size() != 0, 1);
                    if (exp_u.size() != 0) begin
                        u = exp_u.pop_front();
                        chk("update_hash", update_hash, u.hash);
                        chk("search_hash", search_hash, u.hash);
                        chk("update_ptr", update_ptr, u.ptr);
                    end
                end
            end
        end
    end

    // reference: one candidate per byte; positions with 4 bytes ahead are hashed and looked up
    task automatic model_stream(input logic [7:0] bs[$]);
        int n;
        cand_t c;
        upd_t u;
        logic [31:0] w, h;
        n = bs.size();
        for (int p = 0; p < n; p++) begin
            c.pos = p; c.b = bs[p]; c.last = (p == n - 1); c.h = 0; c.ptr = 0;
            if (p + 4 <= n) begin
                w = {bs[p+3], bs[p+2], bs[p+1], bs[p]};
                h = w * PRIME;
                if (model.exists(h) && model[h] < p) begin
                    c.h = 1;
                    c.ptr = model[h];
`ifdef LZ_HF_MAX_DIST_EN
                    if (p - model[h] > MD) begin c.h = 0; c.ptr = 0; end
`endif
                end
                model[h] = p;
                u.hash = h; u.ptr = p;
                exp_u.push_back(u);
            end
            exp_c.push_back(c);
        end
    endtask

    task automatic send(input logic [7:0] bs[$]);
        logic ok;
        int w;
        model_stream(bs);
        for (int i = 0; i < bs.size(); i++) begin
            if (gaps) while ($urandom_range(0, 3) == 0) begin in_valid = 0; @(posedge clk); #1; end
            in_valid = 1; in_byte = bs[i]; in_last = (i == bs.size() - 1);
            w = 0;
            do begin @(negedge clk); ok = in_ready; @(posedge clk); #1; w++; end while (!ok && w < 500);
            if (!ok) chk("accept_timeout", ok, 1);
        end
        in_valid = 0; in_last = 0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_c.size() != 0 || exp_u.size() != 0) && w < 2000) begin @(posedge clk); #1; w++; end
        chk("drain_cands_left", exp_c.size(), 0);
        chk("drain_upds_left", exp_u.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cand_valid"}, cand_valid, 0);
        chk({tag, "_cand_pos"}, cand_pos, 0);
        chk({tag, "_cand_byte"}, cand_byte, 0);
        chk({tag, "_cand_hit"}, cand_hit, 0);
        chk({tag, "_cand_ptr"}, cand_ptr, 0);
        chk({tag, "_cand_last"}, cand_last, 0);
        chk({tag, "_update_en"}, update_en, 0);
        chk({tag, "_update_ptr"}, update_ptr, 0);
        chk({tag, "_search_hash"}, search_hash, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic run_stream(input string tag, input logic [7:0] bs[$], input int nc, input int nu, input int nh);
        int c0, u0, h0;
        c0 = n_cand; u0 = n_upd; h0 = n_hit;
        send(bs);
        drain();
        chk({tag, "_cands"}, n_cand - c0, nc);
        chk({tag, "_updates"}, n_upd - u0, nu);
        chk({tag, "_hits"}, n_hit - h0, nh);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [31:0] hs;
        int n, c0;
        #2 rst_n = 0;
        #1 chk_reset("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        q = {8'h61, 8'h62, 8'h63, 8'h64, 8'h61, 8'h62, 8'h63, 8'h64};
        run_stream("basic", q, 8, 5, BASIC_HITS);

        q = {8'hAA, 8'hBB, 8'hCC};
        run_stream("short", q, 3, 0, 0);

        q = {8'h01, 8'h02, 8'h03, 8'h04};
        run_stream("last_on_4th", q, 4, 1, 0);

        hs = 32'h88776655 * PRIME;
        stub[hs] = 32'd100; model[hs] = 32'd100; cache_gen++;
        q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_stream("stale", q, 8, 5, 0);

        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(8'h41 + 8'($urandom_range(0, 3)));
        c0 = n_cand;
        fork
            send(q);
            begin
                repeat (8) @(posedge clk);
                stall = 1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k > 0) chk("stall_in_ready", in_ready, 0);
                end
                stall = 0;
            end
        join
        drain();
        chk("stall_cands", n_cand - c0, 16);

        rand_bp = 1; gaps = 1;
        for (int s = 0; s < 30; s++) begin
            q.delete();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) q.push_back(8'h41 + 8'($urandom_range(0, 3)));
            send(q);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        drain();
        rand_bp = 0; gaps = 0;
        @(posedge clk); #1;

        sb_off = 1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_byte = 8'h30 + 8'(i); in_last = 0;
            @(posedge clk); #1;
        end
        #2 rst_n = 0;
        #1 chk_reset("rst_mid");
        in_valid = 0;
        exp_c.delete(); exp_u.delete(); stub.delete(); model.delete(); cache_gen++;
        @(posedge clk); #1 rst_n = 1; sb_off = 0;
        @(posedge clk); #1;
        q = {8'h61, 8'h62, 8'h63, 8'h64, 8'h61, 8'h62, 8'h63, 8'h64};
        run_stream("after_reset", q, 8, 5, BASIC_HITS);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
